ncl_ula_host: RTL

NCL_ULA_HOST -- requirements
Module: ncl_ula_host

---
 rtl/ncl_ula_host_if.sv | 26 ++
 rtl/ncl_ula_host.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/ncl_ula_host_if.sv
// Single-rail request/response bundle between a client (master) and the NCL ULA host (slave).
interface ncl_ula_host_if;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] req_a;
    logic [3:0] req_b;
    logic       req_opr;

    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_soma;
    logic       rsp_of;
    logic       rsp_zero;
    logic       rsp_neg;
    logic       rsp_err;

    modport master (
        output req_valid, req_a, req_b, req_opr, rsp_ready,
        input  req_ready, rsp_valid, rsp_soma, rsp_of, rsp_zero, rsp_neg, rsp_err
    );

    modport slave (
        input  req_valid, req_a, req_b, req_opr, rsp_ready,
        output req_ready, rsp_valid, rsp_soma, rsp_of, rsp_zero, rsp_neg, rsp_err
    );
endinterface

// File: rtl/ncl_ula_host.sv
// Synchronous host for an asynchronous dual-rail (NCL) ULA stage: encodes one token, runs DATA/NULL, returns flags.
// Optional watchdog: define NCL_HOST_TIMEOUT_EN to abort a stalled stage after TIMEOUT_CYCLES clocks.
module ncl_ula_host #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    ncl_ula_host_if.slave host,
    output logic [7:0]  ncl_a,
    output logic [7:0]  ncl_b,
    output logic [1:0]  ncl_opr,
    output logic        ncl_ack,
    input  logic        ncl_ack_out,
    input  logic [7:0]  ncl_soma,
    input  logic [1:0]  ncl_of,
    input  logic [1:0]  ncl_zero,
    input  logic [1:0]  ncl_neg
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_CAPT,
        ST_NULL,
        ST_RESP
    } state_t;

    localparam int SW = 15;  // ack_out + 7 result rail pairs

    function automatic logic [7:0] enc4(input logic [3:0] v);
        logic [7:0] r;
        for (int i = 0; i < 4; i++) begin
            r[2*i+1] = v[i];
            r[2*i]   = ~v[i];
        end
        return r;
    endfunction

    function automatic logic [3:0] rail1_4(input logic [7:0] r);
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = r[2*i+1];
        return v;
    endfunction

    state_t state_q, state_d;

    logic [SW-1:0] sync_q [SYNC_STAGES];
    logic [SW-1:0] sync_s;
    logic          ack_s;
    logic [13:0]   rails_s;
    logic [6:0]    pair_any, pair_bad;
    logic          complete_now, empty_now;
    logic          data_seen_q, null_seen_q;
    logic          data_ok, null_ok;
    logic          timeout_hit;

    // NOTE: these are individual synchronizer flops, not a RAM, so every stage is reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= {ncl_ack_out, ncl_neg, ncl_zero, ncl_of, ncl_soma};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign sync_s  = sync_q[SYNC_STAGES-1];
    assign ack_s   = sync_s[14];
    assign rails_s = sync_s[13:0];

    always_comb begin
        for (int k = 0; k < 7; k++) begin
            pair_any[k] = |rails_s[2*k +: 2];
            pair_bad[k] = &rails_s[2*k +: 2];
        end
    end

    assign complete_now = ack_s & (&pair_any);
    assign empty_now    = ~ack_s & ~(|rails_s);

    // A phase is accepted only after two consecutive matching samples, which rejects single-cycle glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_seen_q <= 1'b0;
            null_seen_q <= 1'b0;
        end else begin
            data_seen_q <= complete_now;
            null_seen_q <= empty_now;
        end
    end

    assign data_ok = complete_now & data_seen_q;
    assign null_ok = empty_now & null_seen_q;

`ifdef NCL_HOST_TIMEOUT_EN
    localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT_CYCLES);
    logic [7:0] wd_cnt_q;
    logic       in_wait;

    assign in_wait = (state_q == ST_DATA) || (state_q == ST_NULL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    wd_cnt_q <= '0;
        else if (state_d != state_q)   wd_cnt_q <= '0;
        else if (in_wait)              wd_cnt_q <= wd_cnt_q + 8'd1;
    end

    assign timeout_hit = in_wait && (wd_cnt_q == WD_LIMIT);
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout_hit        = 1'b0;
`endif

    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        // NOTE: default first so no path through the case leaves state_d unassigned (no latch).
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (host.req_valid && host.req_ready) state_d = ST_DATA;
            ST_DATA: begin
                if (timeout_hit)  state_d = ST_RESP;
                else if (data_ok) state_d = ST_CAPT;
            end
            ST_CAPT: state_d = ST_NULL;
            ST_NULL: if (timeout_hit || null_ok) state_d = ST_RESP;
            ST_RESP: if (host.rsp_valid && host.rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // All outputs are registered and only move on state transitions, so the stage never sees decode glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            host.req_ready <= 1'b0;
            host.rsp_valid <= 1'b0;
            host.rsp_soma  <= '0;
            host.rsp_of    <= 1'b0;
            host.rsp_zero  <= 1'b0;
            host.rsp_neg   <= 1'b0;
            host.rsp_err   <= 1'b0;
            ncl_a          <= '0;
            ncl_b          <= '0;
            ncl_opr        <= '0;
            ncl_ack        <= 1'b0;
        end else begin
            host.req_ready <= (state_d == ST_IDLE);
            host.rsp_valid <= (state_d == ST_RESP);

            if (state_q == ST_IDLE && state_d == ST_DATA) begin
                ncl_a   <= enc4(host.req_a);
                ncl_b   <= enc4(host.req_b);
                ncl_opr <= {host.req_opr, ~host.req_opr};
            end else if (state_d != ST_DATA && state_d != ST_CAPT) begin
                ncl_a   <= '0;
                ncl_b   <= '0;
                ncl_opr <= '0;
            end

            if (state_q == ST_CAPT || timeout_hit)
                ncl_ack <= 1'b1;
            else if ((state_q == ST_NULL && state_d == ST_RESP) || state_d == ST_IDLE)
                ncl_ack <= 1'b0;

            if (state_q == ST_CAPT) begin
                host.rsp_soma <= rail1_4(rails_s[7:0]);
                host.rsp_of   <= rails_s[9];
                host.rsp_zero <= rails_s[11];
                host.rsp_neg  <= rails_s[13];
                host.rsp_err  <= |pair_bad;
            end else if (timeout_hit) begin
                host.rsp_soma <= '0;
                host.rsp_of   <= 1'b0;
                host.rsp_zero <= 1'b0;
                host.rsp_neg  <= 1'b0;
                host.rsp_err  <= 1'b1;
            end
        end
    end

endmodule
